aes_arb: RTL

Two-port arbiter and sequencer that shares one `aes` core between two independent requesters. It grants one request at a time and caches the loaded key context {key, enc}. It issues `key_ld_p` only when the granted context differs from the cached one, then drives the core's din/dout handshakes and routes the result back to the owning requester. It sits between the core and its two clients, such as a DMA channel and a register-mapped CPU port.

---
 rtl/aes_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/aes_arb.sv
// aes_arb: shares one aes core between two requesters. Grants one request at a
// time, caches the key context loaded into the core and reloads it only on a
// context change, then sequences the core's din/dout handshakes and routes the
// result back to the requester that owns the grant.
module aes_arb #(
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_vld,
    output logic         req0_rdy,
    input  logic [127:0] req0_key,
    input  logic         req0_enc,
    input  logic [127:0] req0_din,
    input  logic         req1_vld,
    output logic         req1_rdy,
    input  logic [127:0] req1_key,
    input  logic         req1_enc,
    input  logic [127:0] req1_din,
    output logic         rsp0_vld,
    input  logic         rsp0_rdy,
    output logic [127:0] rsp0_dout,
    output logic         rsp1_vld,
    input  logic         rsp1_rdy,
    output logic [127:0] rsp1_dout,
    output logic         aes_key_ld_p,
    output logic [127:0] aes_key,
    output logic         aes_enc,
    output logic         aes_din_vld,
    output logic [127:0] aes_din,
    input  logic         aes_din_rdy,
    input  logic         aes_dout_vld,
    input  logic [127:0] aes_dout,
    output logic         aes_dout_rdy,
    output logic         busy,
    output logic         owner
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEYLD = 3'd1;
    localparam logic [2:0] ST_KWAIT = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_RECV  = 3'd4;

    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [127:0]  ctx_key_reg;
    logic          ctx_enc_reg;
    logic          ctx_vld_reg;
    logic [127:0]  din_q_reg;
    logic          owner_reg;
    logic [CW-1:0] burst_cnt_reg;

    logic          gnt_vld;
    logic          gnt_sel;
    logic [127:0]  gnt_key;
    logic          gnt_enc;
    logic [127:0]  gnt_din;
    logic          ctx_hit;
    logic          in_idle;
    logic          in_recv;
    logic          take;
    logic          rsp_rdy_sel;

    // Pick the requester to grant and compare its context against the cache.
    always_comb begin
        gnt_vld = req0_vld | req1_vld;
        gnt_sel = req1_vld;
        if (req0_vld && req1_vld) begin
            // The current owner keeps the core until its burst is used up.
            gnt_sel = (burst_cnt_reg < BURST_LIMIT) ? owner_reg : ~owner_reg;
        end
        gnt_key = gnt_sel ? req1_key : req0_key;
        gnt_enc = gnt_sel ? req1_enc : req0_enc;
        gnt_din = gnt_sel ? req1_din : req0_din;
        ctx_hit = ctx_vld_reg && (gnt_key == ctx_key_reg) && (gnt_enc == ctx_enc_reg);
    end

    assign in_idle     = (state_reg == ST_IDLE);
    assign in_recv     = (state_reg == ST_RECV);
    assign take        = in_idle & gnt_vld;
    assign rsp_rdy_sel = owner_reg ? rsp1_rdy : rsp0_rdy;

    // Sequencer next-state: a context miss detours through KEYLD/KWAIT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (gnt_vld) state_next = ctx_hit ? ST_SEND : ST_KEYLD;
            ST_KEYLD: state_next = ST_KWAIT;
            ST_KWAIT: state_next = ST_SEND;
            ST_SEND:  if (aes_din_rdy) state_next = ST_RECV;
            ST_RECV:  if (aes_dout_vld && rsp_rdy_sel) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, cached context, captured block and burst accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ctx_key_reg   <= '0;
            ctx_enc_reg   <= 1'b0;
            ctx_vld_reg   <= 1'b0;
            din_q_reg     <= '0;
            owner_reg     <= 1'b0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                din_q_reg   <= gnt_din;
                ctx_key_reg <= gnt_key;
                ctx_enc_reg <= gnt_enc;
                owner_reg   <= gnt_sel;
                if (gnt_sel != owner_reg) begin
                    burst_cnt_reg <= CW'(1);
                end else if (burst_cnt_reg != BURST_LIMIT) begin
                    burst_cnt_reg <= burst_cnt_reg + 1'b1;
                end
            end
            // The context becomes trustworthy once the core has been told to load it.
            if (state_reg == ST_KEYLD) begin
                ctx_vld_reg <= 1'b1;
            end
        end
    end

    assign req0_rdy     = take & ~gnt_sel;
    assign req1_rdy     = take & gnt_sel;

    assign aes_key_ld_p = (state_reg == ST_KEYLD);
    assign aes_key      = ctx_key_reg;
    assign aes_enc      = ctx_enc_reg;
    assign aes_din_vld  = (state_reg == ST_SEND);
    assign aes_din      = din_q_reg;
    assign aes_dout_rdy = in_recv & rsp_rdy_sel;

    // Only the owner ever sees a valid response; data is shared by both ports.
    assign rsp0_vld     = in_recv & ~owner_reg & aes_dout_vld;
    assign rsp1_vld     = in_recv & owner_reg & aes_dout_vld;
    assign rsp0_dout    = aes_dout;
    assign rsp1_dout    = aes_dout;

    assign busy         = ~in_idle;
    assign owner        = owner_reg;

endmodule
